// File: rtl/sector_sequencer_if.sv
// Request handshake bundle for sector_sequencer.
// The master offers a sector request; the slave accepts it while req_ready is high.
interface sector_sequencer_if;
  logic       req_valid;
  logic [3:0] req_sector;
  logic       req_write;
  logic       req_ready;

  modport master (output req_valid, output req_sector, output req_write, input req_ready);
  modport slave  (input req_valid, input req_sector, input req_write, output req_ready);
endinterface

// File: rtl/sector_sequencer.sv
// sector_sequencer: waits for a requested sector on a rotating medium, counts a
// preamble after its strobe, then opens a fixed-length transfer window.
// A sector strobe edge during preamble/transfer is an overrun and aborts with error.
// Optional macro SECTOR_SEQ_TIMEOUT_EN: abort a WAIT after TIMEOUT_REVS index edges.
module sector_sequencer #(
  parameter int unsigned PREAMBLE_CYCLES = 200,
  parameter int unsigned XFER_CYCLES     = 3000,
  parameter int unsigned TIMEOUT_REVS    = 2
) (
  input  logic              clk25,
  input  logic              reset,
  sector_sequencer_if.slave req_bus,
  input  logic              sector_strobe,
  input  logic              index_strobe,
  input  logic [4:0]        sector,
  output logic              busy,
  output logic              xfer_active,
  output logic              xfer_write,
  output logic [11:0]       xfer_cycle,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PREAMBLE,
    ST_TRANSFER,
    ST_DONE
  } state_t;

  localparam logic [11:0] PRE_LAST  = 12'(PREAMBLE_CYCLES - 1);
  localparam logic [11:0] XFER_LAST = 12'(XFER_CYCLES - 1);

  state_t      state, state_n;
  logic        sector_q, index_q;
  logic        sector_edge, index_edge;
  logic [3:0]  target;
  logic        write_q;
  logic [11:0] cnt, cnt_n;
  logic        err_q, err_n;
  logic        target_match;
  logic        sector_unused;

`ifdef SECTOR_SEQ_TIMEOUT_EN
  localparam logic [7:0] REV_LAST = 8'(TIMEOUT_REVS - 1);
  logic [7:0] revs, revs_n;
`else
  localparam int unsigned TIMEOUT_REVS_UNUSED = TIMEOUT_REVS;
  logic index_unused;
  assign index_unused = index_edge;
`endif

  // Only the low four sector bits identify a sector within a revolution.
  assign sector_unused = sector[4];

  assign sector_edge  = sector_strobe & ~sector_q;
  assign index_edge   = index_strobe & ~index_q;
  assign target_match = sector_edge && (sector[3:0] == target);

  // Previous-cycle copies of the strobes for rising-edge detection.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      sector_q <= 1'b0;
      index_q  <= 1'b0;
    end else begin
      sector_q <= sector_strobe;
      index_q  <= index_strobe;
    end
  end

  // Capture target sector and direction when a request is accepted.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      target  <= '0;
      write_q <= 1'b0;
    end else if (req_bus.req_valid && req_bus.req_ready) begin
      target  <= req_bus.req_sector;
      write_q <= req_bus.req_write;
    end
  end

  // State, shared preamble/transfer counter and registered error pulse.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
`ifdef SECTOR_SEQ_TIMEOUT_EN
      revs  <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= err_n;
`ifdef SECTOR_SEQ_TIMEOUT_EN
      revs  <= revs_n;
`endif
    end
  end

  // Next-state logic; error is flagged on the transition back to IDLE so it
  // can never coincide with the DONE state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
`ifdef SECTOR_SEQ_TIMEOUT_EN
    revs_n  = revs;
`endif
    unique case (state)
      ST_IDLE: begin
        if (req_bus.req_valid) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
`ifdef SECTOR_SEQ_TIMEOUT_EN
          revs_n  = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (target_match) begin
          cnt_n   = '0;
          state_n = (PREAMBLE_CYCLES == 0) ? ST_TRANSFER : ST_PREAMBLE;
        end
`ifdef SECTOR_SEQ_TIMEOUT_EN
        else if (index_edge) begin
          if (revs == REV_LAST) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            revs_n = revs + 8'd1;
          end
        end
`endif
      end
      ST_PREAMBLE: begin
        if (sector_edge) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (cnt == PRE_LAST) begin
          cnt_n   = '0;
          state_n = ST_TRANSFER;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      ST_TRANSFER: begin
        if (sector_edge) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (cnt == XFER_LAST) begin
          cnt_n   = '0;
          state_n = ST_DONE;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign req_bus.req_ready = (state == ST_IDLE);
  assign busy              = (state != ST_IDLE);
  assign xfer_active       = (state == ST_TRANSFER);
  assign xfer_write        = write_q & xfer_active;
  assign xfer_cycle        = xfer_active ? cnt : '0;
  assign done              = (state == ST_DONE);
  assign error             = err_q;

endmodule

// File: tb/tb_sector_sequencer.sv
// Directed bench for sector_sequencer: three instances (default timing,
// long transfer for overrun, zero preamble) share clock, reset and strobes.
`timescale 1ns/1ps
module tb_sector_sequencer;

  logic       clk25 = 1'b0;
  logic       reset;
  logic       sector_strobe;
  logic       index_strobe;
  logic [4:0] sector;

  logic        busy [3];
  logic        act  [3];
  logic        wr   [3];
  logic        dn   [3];
  logic        err  [3];
  logic        rdy  [3];
  logic [11:0] xc   [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #200 clk25 = ~clk25;

  sector_sequencer_if bus0 ();
  sector_sequencer_if bus1 ();
  sector_sequencer_if bus2 ();

  assign rdy[0] = bus0.req_ready;
  assign rdy[1] = bus1.req_ready;
  assign rdy[2] = bus2.req_ready;

  sector_sequencer dut0 (
    .clk25(clk25), .reset(reset), .req_bus(bus0.slave),
    .sector_strobe(sector_strobe), .index_strobe(index_strobe), .sector(sector),
    .busy(busy[0]), .xfer_active(act[0]), .xfer_write(wr[0]),
    .xfer_cycle(xc[0]), .done(dn[0]), .error(err[0])
  );

  sector_sequencer #(.PREAMBLE_CYCLES(200), .XFER_CYCLES(3800)) dut1 (
    .clk25(clk25), .reset(reset), .req_bus(bus1.slave),
    .sector_strobe(sector_strobe), .index_strobe(index_strobe), .sector(sector),
    .busy(busy[1]), .xfer_active(act[1]), .xfer_write(wr[1]),
    .xfer_cycle(xc[1]), .done(dn[1]), .error(err[1])
  );

  sector_sequencer #(.PREAMBLE_CYCLES(0), .XFER_CYCLES(5)) dut2 (
    .clk25(clk25), .reset(reset), .req_bus(bus2.slave),
    .sector_strobe(sector_strobe), .index_strobe(index_strobe), .sector(sector),
    .busy(busy[2]), .xfer_active(act[2]), .xfer_write(wr[2]),
    .xfer_cycle(xc[2]), .done(dn[2]), .error(err[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic set_req(input int d, input logic v, input logic [3:0] s, input logic w);
    case (d)
      0: begin bus0.req_valid = v; bus0.req_sector = s; bus0.req_write = w; end
      1: begin bus1.req_valid = v; bus1.req_sector = s; bus1.req_write = w; end
      default: begin bus2.req_valid = v; bus2.req_sector = s; bus2.req_write = w; end
    endcase
  endtask

  // Offer one request for a single cycle; the instance is idle so it is accepted.
  task automatic request(input int d, input logic [3:0] s, input logic w);
    set_req(d, 1'b1, s, w);
    tick();
    set_req(d, 1'b0, 4'd0, 1'b0);
  endtask

  // Full-width 120-cycle sector pulse; the falling edge is scheduled in the background.
  task automatic strobe_on(input logic [4:0] n);
    sector        = n;
    sector_strobe = 1'b1;
    index_strobe  = (n[3:0] == 4'd0);
    fork
      begin
        repeat (120) @(posedge clk25);
        #1;
        sector_strobe = 1'b0;
        index_strobe  = 1'b0;
      end
    join_none
  endtask

  // Short pulse used to step through sectors quickly while a request waits.
  task automatic quick(input logic [4:0] n);
    sector        = n;
    sector_strobe = 1'b1;
    index_strobe  = (n[3:0] == 4'd0);
    tick();
    tick();
    sector_strobe = 1'b0;
    index_strobe  = 1'b0;
    tick();
    tick();
  endtask

  // From the strobe edge cycle: measure window start and length, then the done pulse.
  task automatic run_xfer(input int d, input int exp_rise, input int exp_len,
                          input logic exp_wr, input string tag);
    int n = 0;
    int len = 0;
    while (!act[d] && n < 5000) begin
      tick();
      n++;
    end
    check({tag, "_rise"}, n, exp_rise);
    check({tag, "_write"}, wr[d], exp_wr);
    check({tag, "_cycle_first"}, xc[d], 0);
    while (act[d] && len < 5000) begin
      if (len == exp_len - 1) check({tag, "_cycle_last"}, xc[d], exp_len - 1);
      if (err[d] || dn[d]) check({tag, "_pulse_in_window"}, 1, 0);
      tick();
      len++;
    end
    check({tag, "_len"}, len, exp_len);
    check({tag, "_done"}, dn[d], 1);
    check({tag, "_err"}, err[d], 0);
    check({tag, "_ready_in_done"}, rdy[d], 0);
    tick();
    check({tag, "_done_one_cycle"}, dn[d], 0);
    check({tag, "_ready_idle"}, rdy[d], 1);
    check({tag, "_busy_idle"}, busy[d], 0);
  endtask

  initial begin
    int n;
    logic saw;

    reset         = 1'b1;
    sector_strobe = 1'b0;
    index_strobe  = 1'b0;
    sector        = 5'd2;
    for (int d = 0; d < 3; d++) set_req(d, 1'b0, 4'd0, 1'b0);
    tick();
    tick();
    check("rst_busy", busy[0], 0);
    check("rst_active", act[0], 0);
    check("rst_write", wr[0], 0);
    check("rst_cycle", xc[0], 0);
    check("rst_done", dn[0], 0);
    check("rst_err", err[0], 0);
    reset = 1'b0;
    tick();
    check("rst_ready", rdy[0], 1);

    // Sector 5 read requested while the head is over sector 2.
    request(0, 4'd5, 1'b0);
    check("s5_busy", busy[0], 1);
    check("s5_ready_low", rdy[0], 0);
    quick(5'd3);
    quick(5'd4);
    check("s5_no_early_xfer", act[0], 0);
    strobe_on(5'd5);
    run_xfer(0, 201, 3000, 1'b0, "s5rd");

    // Sector 0 write accepted in the very cycle of the sector-0 edge: must not match.
    strobe_on(5'd0);
    request(0, 4'd0, 1'b1);
    repeat (125) tick();
    check("s0_same_cycle_nomatch", act[0], 0);
    check("s0_same_cycle_busy", busy[0], 1);
    for (int s = 1; s < 16; s++) quick(5'(s));
    check("s0_rev_nomatch", act[0], 0);
    strobe_on(5'd0);
    run_xfer(0, 201, 3000, 1'b1, "s0wr");

    // Reset in the middle of a transfer.
    request(0, 4'd9, 1'b0);
    strobe_on(5'd9);
    n = 0;
    while (xc[0] != 12'd1000 && n < 5000) begin
      tick();
      n++;
    end
    check("mid_cycle_1000", xc[0], 1000);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_active", act[0], 0);
    check("mid_rst_cycle", xc[0], 0);
    check("mid_rst_done", dn[0], 0);
    check("mid_rst_err", err[0], 0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_ready", rdy[0], 1);
    saw = 1'b0;
    repeat (10) begin
      tick();
      saw = saw | dn[0] | err[0] | busy[0];
    end
    check("mid_rst_no_pulse", saw, 0);

    // Long transfer overrun by the next sector edge 3906 cycles after the match.
    request(1, 4'd3, 1'b1);
    strobe_on(5'd3);
    repeat (3906) tick();
    check("ovr_active", act[1], 1);
    check("ovr_cycle", xc[1], 3705);
    strobe_on(5'd4);
    tick();
    check("ovr_err", err[1], 1);
    check("ovr_active_drop", act[1], 0);
    check("ovr_no_done", dn[1], 0);
    check("ovr_idle", busy[1], 0);
    tick();
    check("ovr_err_one_cycle", err[1], 0);
    saw = 1'b0;
    repeat (150) begin
      tick();
      saw = saw | dn[1];
    end
    check("ovr_never_done", saw, 0);

    // Zero preamble; sector bit 4 set must be ignored when comparing.
    request(2, 4'd1, 1'b1);
    strobe_on(5'd17);
    run_xfer(2, 1, 5, 1'b1, "p0");
    repeat (125) tick();

    // Only index strobes arrive while waiting for sector 7.
    request(0, 4'd7, 1'b0);
    quick(5'd0);
    check("to_first_index_busy", busy[0], 1);
    sector        = 5'd0;
    sector_strobe = 1'b1;
    index_strobe  = 1'b1;
    tick();
`ifdef SECTOR_SEQ_TIMEOUT_EN
    check("to_err", err[0], 1);
    check("to_idle", busy[0], 0);
`else
    check("nto_err", err[0], 0);
    check("nto_busy", busy[0], 1);
`endif
    sector_strobe = 1'b0;
    index_strobe  = 1'b0;
    tick();
    quick(5'd0);
    quick(5'd0);
`ifdef SECTOR_SEQ_TIMEOUT_EN
    check("to_stays_idle", busy[0], 0);
`else
    check("nto_still_busy", busy[0], 1);
`endif

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
